// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: instruction register with an in-order prefetch queue.
// Sits between instruction fetch and the control-unit decoder.
// Ports:
//   CLK, Reset (async, active-high)
//   in_valid / Instruction / in_ready   fetch-side handshake
//   out_valid / OutputInst / opCode / out_ready  decode-side handshake
//   flush   drops all buffered entries at the next edge
//   count   current occupancy
//   stall_cnt  head-stall cycle counter (only with IRQ_STALL_CNT_EN)
// Optional feature macro: IRQ_STALL_CNT_EN
module ir_prefetch_queue #(
    parameter int INST_W = 16,
    parameter int OPC_W  = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     in_valid,
    input  logic [INST_W-1:0]        Instruction,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_W-1:0]        OutputInst,
    output logic [OPC_W-1:0]         opCode,
    input  logic                     flush,
`ifdef IRQ_STALL_CNT_EN
    output logic [15:0]              stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;

    // Handshake flags depend on occupancy only, never on the
    // same-cycle valid/ready inputs.
    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);

    // A flush cancels any push/pop offered in the same cycle.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uncleared; the pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= Instruction;
    end

    assign OutputInst = out_valid ? mem_q[rd_ptr_q] : '0;
    assign opCode     = OutputInst[INST_W-1 -: OPC_W];
    assign count      = count_q;

`ifdef IRQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (flush)
            stall_d = '0;
        else if (out_valid && !out_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/ir_prefetch_queue.md
# ir_prefetch_queue

Parametrised instruction register with a small prefetch queue, sitting between instruction memory fetch and the control-unit decoder of the accumulator processor. It captures fetched instructions through a valid/ready handshake, buffers up to DEPTH of them in order, and presents the oldest instruction with its opcode field split out. A flush input discards all buffered instructions on a taken branch or jump.

## Interface

Parameters:
- INST_W, 16, instruction width in bits.
- OPC_W, 5, opcode width; opcode is Instruction[INST_W-1 -: OPC_W].
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- CLK  input  1  single clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  fetch presents an instruction.
- Instruction  input  INST_W  fetched instruction word.
- in_ready  output  1  queue can accept; equals (count < DEPTH).
- out_valid  output  1  head entry valid; equals (count != 0).
- out_ready  input  1  decoder consumes the head this cycle.
- OutputInst  output  INST_W  head instruction; 0 when empty.
- opCode  output  OPC_W  head opcode field; 0 when empty.
- flush  input  1  discard all entries at next edge.
- count  output  $clog2(DEPTH)+1  current occupancy.

## Operation

- Storage: DEPTH x INST_W register array, write pointer wr_ptr, read pointer rd_ptr (each $clog2(DEPTH) bits, wrap modulo DEPTH), occupancy count.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- On push: mem[wr_ptr] <= Instruction; wr_ptr <= wr_ptr+1.
- On pop: rd_ptr <= rd_ptr+1.
- count <= count + push - pop; push and pop in same cycle leave count unchanged.
- Full (count==DEPTH): in_ready low, no push, even if pop occurs this cycle (no pass-through on full).
- Empty (count==0): out_valid low, OutputInst and opCode driven 0; out_ready ignored.
- flush: wr_ptr, rd_ptr, count <= 0 at next edge; any simultaneous push and pop are discarded. Array contents are not cleared.
- OutputInst = out_valid ? mem[rd_ptr] : 0; opCode = OutputInst[INST_W-1 -: OPC_W]. Both derived from registered state only, no combinational path from Instruction.
- Order strictly FIFO; no reordering, no drop other than flush.

## Timing

- Reset asserted: pointers, count, and (if enabled) stall counter go to 0 without waiting for CLK; in_ready=1, out_valid=0, OutputInst=0, opCode=0 for as long as Reset is high.
- Reset mid-operation: all buffered entries lost; first push after deassertion lands in entry 0.
- Latency: instruction pushed at edge t appears on OutputInst/opCode just after edge t when queue was empty (1 cycle fetch-to-decode).
- Head changes only on the edge following a pop; holds stable while out_valid & ~out_ready.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- in_ready and out_valid are functions of count only; no dependence on in_valid or out_ready in the same cycle.
- Pointer wrap: after DEPTH pushes wr_ptr returns to 0; data integrity must hold across wrap.

## Configuration

- IRQ_STALL_CNT_EN defined: adds output stall_cnt [15:0], counting cycles where out_valid & ~out_ready; saturates at 16'hFFFF; cleared by Reset and by flush; unchanged otherwise.
- Not defined: stall_cnt port and counter absent; all other behaviour identical.

## Test plan

- Reset then push 16'hA123 with out_ready=0 -> next cycle out_valid=1, OutputInst=16'hA123, opCode=5'h14, count=1, holds for 3 idle cycles.
- Push 16'h0800, 16'h1000, 16'h1800, 16'hF800 with out_ready=0 -> count=4, in_ready=0, fifth push ignored; then out_ready=1 -> opCodes 1, 2, 3, 5'h1F in order, then out_valid=0, opCode=0.
- Continuous in_valid and out_ready=1 for 10 instructions 16'h0001..16'h000A -> each appears one cycle after push, count stays 1, pointers wrap twice, no loss.
- Full queue with out_ready=1 and in_valid=1 in same cycle -> pop only, count goes 4->3, the offered word accepted on the following cycle.
- count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, OutputInst=0; next push shows at head.
- With IRQ_STALL_CNT_EN: hold valid head with out_ready=0 for 5 cycles -> stall_cnt=5; assert Reset asynchronously mid-cycle -> stall_cnt, count, out_valid read 0 before next CLK edge.
